// File: rtl/regfile_dump_restore.sv
// Register-file dump/restore sequencer: walks FIRST_REG..LAST_REG,
// streaming reads out (dump) or writing a stream back (restore).
module regfile_dump_restore #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic [4:0]  o_rf_a_reg,
  input  logic [31:0] i_rf_a,
  output logic        o_rf_write_back_en,
  output logic [4:0]  o_rf_write_back_reg,
  output logic [31:0] o_rf_write_back,
  output logic [31:0] o_dout,
  output logic        o_dout_valid,
  input  logic        i_dout_ready,
  input  logic [31:0] i_din,
  input  logic        i_din_valid,
  output logic        o_din_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_RESTORE,
    S_DONE
  } state_t;

  localparam logic [4:0] LP_FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LP_LAST  = 5'(LAST_REG);

  state_t     r_state;
  logic [4:0] r_idx;
  logic       w_din_hs;

  assign o_din_ready = (r_state == S_RESTORE) && !i_abort;
  assign w_din_hs    = o_din_ready && i_din_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_rf_a_reg  = (r_state == S_DUMP_RD) ? r_idx : 5'd0;

  // The write pulse is launched from the handshake before the state update,
  // so a write registered in the cycle before an abort still completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state             <= S_IDLE;
      r_idx               <= 5'd0;
      o_rf_write_back_en  <= 1'b0;
      o_rf_write_back_reg <= 5'd0;
      o_rf_write_back     <= 32'd0;
      o_dout              <= 32'd0;
      o_dout_valid        <= 1'b0;
    end else begin
      o_rf_write_back_en <= w_din_hs;
      if (w_din_hs) begin
        o_rf_write_back_reg <= r_idx;
        o_rf_write_back     <= i_din;
      end

      if (i_abort && (r_state != S_IDLE)) begin
        r_state      <= S_IDLE;
        o_dout_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_idx   <= LP_FIRST;
              r_state <= i_mode ? S_RESTORE : S_DUMP_RD;
            end
          end
          S_DUMP_RD: begin
            o_dout       <= i_rf_a;
            o_dout_valid <= 1'b1;
            r_state      <= S_DUMP_WAIT;
          end
          S_DUMP_WAIT: begin
            if (i_dout_ready) begin
              o_dout_valid <= 1'b0;
              if (r_idx == LP_LAST) begin
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + 5'd1;
                r_state <= S_DUMP_RD;
              end
            end
          end
          S_RESTORE: begin
            if (w_din_hs) begin
              if (r_idx == LP_LAST) begin
                r_state <= S_DONE;
              end else begin
                r_idx <= r_idx + 5'd1;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump_restore.sv
// Scoreboard bench for regfile_dump_restore: default-range instance plus a
// single-register (5..5) instance driven by the same stimulus.
module tb_regfile_dump_restore;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mode, abort, doutReady, dinValid;
  logic [31:0] din;

  logic        busy, done, wbEn, doutValid, dinReady;
  logic [4:0]  rfAReg, wbReg;
  logic [31:0] rfA, wbData, dout;

  logic        busy1, done1, wbEn1, doutValid1, dinReady1;
  logic [4:0]  rfAReg1, wbReg1;
  logic [31:0] rfA1, wbData1, dout1;

  regfile_dump_restore dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_rf_a_reg(rfAReg), .i_rf_a(rfA),
    .o_rf_write_back_en(wbEn), .o_rf_write_back_reg(wbReg), .o_rf_write_back(wbData),
    .o_dout(dout), .o_dout_valid(doutValid), .i_dout_ready(doutReady),
    .i_din(din), .i_din_valid(dinValid), .o_din_ready(dinReady)
  );

  regfile_dump_restore #(.FIRST_REG(5), .LAST_REG(5)) dutOne (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_abort(abort),
    .o_busy(busy1), .o_done(done1), .o_rf_a_reg(rfAReg1), .i_rf_a(rfA1),
    .o_rf_write_back_en(wbEn1), .o_rf_write_back_reg(wbReg1), .o_rf_write_back(wbData1),
    .o_dout(dout1), .o_dout_valid(doutValid1), .i_dout_ready(doutReady),
    .i_din(din), .i_din_valid(dinValid), .o_din_ready(dinReady1)
  );

  // Register file model for the main instance
  logic [31:0] regs [32];
  logic        preloadEn;
  assign rfA  = regs[rfAReg];
  assign rfA1 = 32'hC0DE_0000 | {27'd0, rfAReg1};

  always @(posedge clk) begin
    if (preloadEn) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h100 + 32'(i);
    end else if (wbEn) begin
      regs[wbReg] <= wbData;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] expQ [$];
  logic [36:0] wrQ [$];
  logic [31:0] expRegs [32];

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int          t0, relM, nDumped, nWr, dinK, doneCycle, doneCount;
  int          lastDumpHs, lastDinHs, done1Cycle, abortAt, rstAt;
  logic        monOn, chkTiming, prevStall, seen1d, seen1w;
  logic [31:0] prevDout, dout1Seen;
  logic [36:0] wr1Seen;

  // Output monitor: pops the scoreboards on every DUT transfer
  always @(negedge clk) begin
    if (monOn) begin
      relM = cyc - t0;
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall)
          checkOutput("stall_hold", {31'd0, doutValid, dout}, {31'd0, 1'b1, prevDout});
        prevStall = doutValid && !doutReady && !abort;
        prevDout  = dout;
      end
      if (doutValid && doutReady && !abort && !rst) begin
        if (expQ.size() != 0) checkOutput("dump_data", 64'(dout), 64'(expQ.pop_front()));
        if (chkTiming) checkOutput("dump_cycle", 64'(relM), 64'(2 + 2 * nDumped));
        nDumped++;
        lastDumpHs = relM;
      end
      if (wbEn) begin
        if (wrQ.size() != 0) checkOutput("wr_data", {27'd0, wbReg, wbData}, {27'd0, wrQ.pop_front()});
        if (chkTiming) checkOutput("wr_cycle", 64'(relM), 64'(2 + nWr));
        nWr++;
      end
      if (dinValid && dinReady) begin
        dinK++;
        lastDinHs = relM;
      end
      if (done) begin
        doneCount++;
        doneCycle = relM;
      end
      if (done1 && done1Cycle < 0) done1Cycle = relM;
      if (doutValid1 && doutReady && !seen1d) begin
        seen1d    = 1'b1;
        dout1Seen = dout1;
      end
      if (wbEn1 && !seen1w) begin
        seen1w  = 1'b1;
        wr1Seen = {wbReg1, wbData1};
      end
      if (relM == abortAt) checkOutput("abort_din_ready", 64'(dinReady), 64'd0);
      if (relM == abortAt + 1) checkOutput("abort_busy", 64'(busy), 64'd0);
      if (relM == rstAt + 1) begin
        checkOutput("rst_ctrl", {49'd0, busy, done, rfAReg, wbEn, wbReg, doutValid, dinReady}, 64'd0);
        checkOutput("rst_data", {wbData, dout}, 64'd0);
      end
    end
  end

  // pat: 0 continuous, 1 dout_ready toggling, 2 din_valid low every third cycle, 3 dout_ready low
  task automatic applyStimulus(input logic m, input int pat, input int ab, input int rs,
                               input int again, input int maxCyc, input logic [31:0] base);
    @(posedge clk);
    #1;
    nDumped = 0; nWr = 0; dinK = 0; doneCount = 0; doneCycle = -1; done1Cycle = -1;
    seen1d = 1'b0; seen1w = 1'b0; prevStall = 1'b0; lastDumpHs = -1; lastDinHs = -1;
    abortAt = ab; rstAt = rs; t0 = cyc; monOn = 1'b1;
    for (int r = 0; r <= maxCyc; r++) begin
      if (r > 0) begin
        @(posedge clk);
        #1;
      end
      start     = (r == 0) || (r == again);
      mode      = m;
      abort     = (r == ab);
      rst       = (r == rs);
      doutReady = (pat == 1) ? (r % 2 == 1) : (pat != 3);
      dinValid  = m && !(pat == 2 && r % 3 == 2);
      din       = base + 32'(dinK);
    end
    monOn = 1'b0; start = 1'b0; abort = 1'b0; rst = 1'b0; dinValid = 1'b0; doutReady = 1'b1;
    abortAt = 9999; rstAt = 9999;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; doutReady = 1'b1;
    dinValid = 1'b0; din = 32'd0; monOn = 1'b0; chkTiming = 1'b0; preloadEn = 1'b1;
    abortAt = 9999; rstAt = 9999;
    for (int i = 0; i < 32; i++) expRegs[i] = 32'h100 + 32'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", {49'd0, busy, done, rfAReg, wbEn, wbReg, doutValid, dinReady}, 64'd0);
    checkOutput("reset_data", {wbData, dout}, 64'd0);
    checkOutput("reset_one", {59'd0, busy1, done1, wbEn1, doutValid1, dinReady1}, 64'd0);
    rst = 1'b0;
    preloadEn = 1'b0;

    // Default dump, plus a start pulse while busy that must be ignored
    chkTiming = 1'b1;
    for (int i = 1; i <= 31; i++) expQ.push_back(expRegs[i]);
    applyStimulus(1'b0, 0, 9999, 9999, 10, 70, 32'd0);
    checkOutput("dump_done_cycle", 64'(doneCycle), 64'd63);
    checkOutput("dump_done_count", 64'(doneCount), 64'd1);
    checkOutput("dump_words", 64'(nDumped), 64'd31);
    checkOutput("dump_queue_left", 64'(expQ.size()), 64'd0);
    checkOutput("dump_no_writes", 64'(nWr), 64'd0);
    checkOutput("dump_idle_after", 64'(busy), 64'd0);
    checkOutput("one_dump_done_cycle", 64'(done1Cycle), 64'd3);
    checkOutput("one_dump_word", 64'(dout1Seen), 64'hC0DE_0005);

    // Default restore
    for (int i = 1; i <= 31; i++) begin
      expRegs[i] = 32'hA000 + 32'(i) - 32'd1;
      wrQ.push_back({5'(i), expRegs[i]});
    end
    applyStimulus(1'b1, 0, 9999, 9999, 9999, 40, 32'hA000);
    checkOutput("restore_done_cycle", 64'(doneCycle), 64'd32);
    checkOutput("restore_writes", 64'(nWr), 64'd31);
    checkOutput("restore_queue_left", 64'(wrQ.size()), 64'd0);
    checkOutput("one_restore_done_cycle", 64'(done1Cycle), 64'd2);
    checkOutput("one_restore_write", 64'(wr1Seen), {27'd0, 5'd5, 32'hA000});

    // Dump back what was restored
    for (int i = 1; i <= 31; i++) expQ.push_back(expRegs[i]);
    applyStimulus(1'b0, 0, 9999, 9999, 9999, 70, 32'd0);
    checkOutput("redump_words", 64'(nDumped), 64'd31);
    checkOutput("redump_queue_left", 64'(expQ.size()), 64'd0);

    // Backpressure on both streams
    chkTiming = 1'b0;
    for (int i = 1; i <= 31; i++) expQ.push_back(expRegs[i]);
    applyStimulus(1'b0, 1, 9999, 9999, 9999, 140, 32'd0);
    checkOutput("bp_dump_words", 64'(nDumped), 64'd31);
    checkOutput("bp_dump_queue_left", 64'(expQ.size()), 64'd0);
    checkOutput("bp_dump_done", 64'(doneCycle), 64'(lastDumpHs + 1));
    for (int i = 1; i <= 31; i++) begin
      expRegs[i] = 32'hB000 + 32'(i) - 32'd1;
      wrQ.push_back({5'(i), expRegs[i]});
    end
    applyStimulus(1'b1, 2, 9999, 9999, 9999, 60, 32'hB000);
    checkOutput("bp_restore_writes", 64'(nWr), 64'd31);
    checkOutput("bp_restore_hs", 64'(dinK), 64'd31);
    checkOutput("bp_restore_queue_left", 64'(wrQ.size()), 64'd0);
    checkOutput("bp_restore_done", 64'(doneCycle), 64'(lastDinHs + 1));

    // Abort a restore in cycle 10
    chkTiming = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      expRegs[i] = 32'hC000 + 32'(i) - 32'd1;
      wrQ.push_back({5'(i), expRegs[i]});
    end
    applyStimulus(1'b1, 0, 10, 9999, 9999, 20, 32'hC000);
    checkOutput("abort_no_done", 64'(doneCount), 64'd0);
    checkOutput("abort_writes", 64'(nWr), 64'd9);
    checkOutput("abort_hs", 64'(dinK), 64'd9);
    checkOutput("abort_queue_left", 64'(wrQ.size()), 64'd0);

    // Reset while stalled in DUMP_WAIT, then a normal dump
    chkTiming = 1'b0;
    applyStimulus(1'b0, 3, 9999, 4, 9999, 8, 32'd0);
    checkOutput("rst_no_words", 64'(nDumped), 64'd0);
    checkOutput("rst_no_done", 64'(doneCount), 64'd0);
    chkTiming = 1'b1;
    for (int i = 1; i <= 31; i++) expQ.push_back(expRegs[i]);
    applyStimulus(1'b0, 0, 9999, 9999, 9999, 70, 32'd0);
    checkOutput("post_rst_done_cycle", 64'(doneCycle), 64'd63);
    checkOutput("post_rst_words", 64'(nDumped), 64'd31);
    checkOutput("post_rst_queue_left", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_restore.md
# regfile_dump_restore

Sequencer that acts as the initiator on the register file's ports, walking a contiguous register range on command. In dump mode it reads each register through one read port and streams the values out over a valid/ready interface. In restore mode it accepts a valid/ready stream and issues one write-back per word. It sits beside the CPU datapath for context save/restore and debug. While `busy` is high, the CPU must not drive the register file write-back port or the read port used here.

## Interface
- `FIRST_REG`, default 1: first register index walked (0–31).
- `LAST_REG`, default 31: last register index walked; must be ≥ `FIRST_REG`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin operation; sampled only in IDLE.
- `mode`  in  1  0 = dump, 1 = restore; sampled together with `start`.
- `abort`  in  1  cancel the current operation.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the operation completes normally.
- `rf_a_reg`  out  5  register file read-port index.
- `rf_a`  in  32  register file read data; combinational from `rf_a_reg`.
- `rf_write_back_en`  out  1  register file write enable.
- `rf_write_back_reg`  out  5  write index.
- `rf_write_back`  out  32  write data.
- `dout`  out  32  dump stream data.
- `dout_valid`  out  1  dump stream valid.
- `dout_ready`  in  1  dump stream ready.
- `din`  in  32  restore stream data.
- `din_valid`  in  1  restore stream valid.
- `din_ready`  out  1  restore stream ready.

## Operation
- **States:** IDLE, DUMP_RD, DUMP_WAIT, RESTORE, DONE. A 5-bit index register `idx` tracks the current register.
- **IDLE:**
  - `start`=1 and `mode`=0 → DUMP_RD.
  - `start`=1 and `mode`=1 → RESTORE.
  - In both cases `idx` ← `FIRST_REG`.
  - `abort` has no effect in IDLE.
- **DUMP_RD:**
  - `rf_a_reg` = `idx`.
  - At the clock edge: `dout` ← `rf_a`, `dout_valid` ← 1, next state DUMP_WAIT.
- **DUMP_WAIT:**
  - `dout` and `dout_valid` hold until `dout_valid` & `dout_ready`.
  - On handshake: `dout_valid` ← 0. If `idx` == `LAST_REG` → DONE; otherwise `idx` ← `idx`+1 and → DUMP_RD.
- **RESTORE:**
  - `din_ready` = 1 whenever in RESTORE and `abort`=0 (combinational).
  - On handshake, registered for the next cycle: `rf_write_back_en` ← 1, `rf_write_back_reg` ← `idx`, `rf_write_back` ← `din`.
  - After a handshake: if `idx` == `LAST_REG` → DONE; otherwise `idx` ← `idx`+1.
  - `rf_write_back_en` is 0 in any cycle not preceded by a handshake.
  - Back-to-back handshakes are allowed.
- **DONE:** `done` = 1 for exactly one cycle, then → IDLE. The final restore write pulse occurs in this cycle.
- **abort** (when `busy`=1):
  - Next state is IDLE; `done` is not pulsed.
  - `dout_valid` ← 0.
  - No handshake is accepted in the abort cycle.
  - A write pulse already registered from the previous cycle still completes.
- **Reset:** takes effect from any state, mid-operation included; no pending write survives.
- **Reset values:** state IDLE, `idx` 0, `busy` 0, `done` 0, `rf_a_reg` 0, `rf_write_back_en` 0, `rf_write_back_reg` 0, `rf_write_back` 0, `dout` 0, `dout_valid` 0, `din_ready` 0.
- **`rf_a_reg` outside DUMP_RD:** 0.
- **Index width:** `idx` is 5 bits and never increments past `LAST_REG`, so there is no wrap-around. `FIRST_REG` == `LAST_REG` transfers exactly one word.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high.
- **Dump,** `dout_ready` held 1:
  - Word k is valid in cycle 2+2k; throughput is 1 word per 2 cycles.
  - For N = `LAST_REG`−`FIRST_REG`+1 words, `done` pulses in cycle 2N+1.
  - With the defaults (N = 31), `done` is in cycle 63 and the block is back in IDLE at cycle 64.
- **Dump backpressure:** each cycle with `dout_ready`=0 in DUMP_WAIT adds one cycle.
- **Restore,** `din_valid` held 1:
  - Handshakes occur in cycles 1..N.
  - Write pulses occur in cycles 2..N+1.
  - `done` pulses in cycle N+1 (cycle 32 with the defaults).
- `busy` is high from cycle 1 until the cycle after DONE.
- `start` asserted while `busy` is ignored.

## Test plan
- **Dump, defaults:** preload r_i = 0x100+i, `dout_ready`=1, `start`,`mode`=0 → 31 words 0x101..0x11F in cycles 2,4,…,62; `done` in cycle 63; `rf_write_back_en` stays 0 throughout.
- **Restore, defaults:** `din` = 0xA000+k with `din_valid`=1 continuously → write pulses in cycles 2..32 with `rf_write_back_reg` = 1..31 and data 0xA000..0xA01E; `done` in cycle 32; a follow-up dump returns the same values.
- **Backpressure:** dump with `dout_ready` toggling 1/0 each cycle, and restore with `din_valid` low every third cycle → no word lost or duplicated; data stable while stalled; `done` only after the last handshake.
- **Abort:** assert `abort` in cycle 10 of a restore → IDLE next cycle; no handshake in cycle 10; writes only for the handshakes before cycle 10; no `done`.
- **Reset mid-operation:** assert `rst` during DUMP_WAIT → all outputs at reset values next cycle; a new `start` works normally.
- **Corner cases:** `FIRST_REG`=`LAST_REG`=5 gives a single word with `done` in cycle 3 (dump) or cycle 2 (restore); `start` during `busy` is ignored.
